// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, TX state enum and frame sizes.
// Optional parity build: UART_TX_PARITY_EN (adds PARITY, 11-bit frame).
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BAUD_RATE_NUMBER_DEFAULT = 10416;
  localparam int UART_BAUD_CNT_W = 14;

`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_BITS = 11;
`else
  localparam int UART_FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: byte valid/ready handshake into the transmitter.
// Ports: tx_data[7:0], tx_valid (master->slave), tx_ready (slave->master).
interface uart_transmitter_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_baud_counter.sv
// uart_tx_baud_counter: restartable 14-bit down-counter, one bit period.
// Ports: clk, rst_n, restart (hold at load), bit_done (count is zero).
module uart_tx_baud_counter
  import uart_pkg::*;
#(
  parameter int BAUD_RATE_NUMBER = BAUD_RATE_NUMBER_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done
);

  localparam logic [UART_BAUD_CNT_W-1:0] LOAD =
    UART_BAUD_CNT_W'(BAUD_RATE_NUMBER - 1);

  logic [UART_BAUD_CNT_W-1:0] cnt;

  assign bit_done = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (restart || bit_done) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 (8E1 with UART_TX_PARITY_EN) serial transmitter.
// Ports: clk, rst_n, bus (slave handshake), tx (line), tx_busy.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int BAUD_RATE_NUMBER = BAUD_RATE_NUMBER_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_transmitter_if.slave   bus,
  output logic                tx,
  output logic                tx_busy
);

  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state, state_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic [2:0]                idx, idx_n;
  logic                      accept;
  logic                      bit_done;
  logic                      tx_n;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_n;
`endif

  assign bus.tx_ready = (state == IDLE);
  assign accept = bus.tx_valid && bus.tx_ready;

  // Counter sits at its load value while idle, so the
  // start bit gets a full period from the accept edge.
  uart_tx_baud_counter #(
    .BAUD_RATE_NUMBER(BAUD_RATE_NUMBER)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (state == IDLE),
    .bit_done (bit_done)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
    tx_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          shreg_n = bus.tx_data;
          idx_n   = '0;
`ifdef UART_TX_PARITY_EN
          par_n   = ^bus.tx_data;
`endif
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_done) state_n = DATA;
      end
      DATA: begin
        tx_n = shreg[0];
        if (bit_done) begin
          shreg_n = shreg >> 1;
          idx_n   = idx + 3'd1;
          if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_n = par_q;
        if (bit_done) state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // tx/tx_busy are registered from the current state, so the
  // line moves one cycle after the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      idx     <= idx_n;
      tx      <= tx_n;
      tx_busy <= (state != IDLE);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed + random frames checked bit-by-bit
// against a frame model built from the byte (start, LSB-first, [parity], stop).
module tb_uart_transmitter;

  localparam int N = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic tx_busy;
  int n_assert = 0;
  int n_fail = 0;

  uart_transmitter_if bus();

  uart_transmitter #(
    .BAUD_RATE_NUMBER(N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  // Bit i of the serial frame for byte b.
  function automatic logic frame_bit(logic [7:0] b, int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present b and return just after the accepting edge k.
  task automatic send_start(logic [7:0] b);
    int w;
    w = 0;
    while (!bus.tx_ready && w < 1000) begin
      step();
      w++;
    end
    chk("ready_wait", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    step();
    chk("ready_drop", 32'(bus.tx_ready), 32'd0);
  endtask

  // Check edges k+1..k+FB*N; optional ignored pulse and early exit.
  task automatic check_frame(logic [7:0] b, int pulse_at, int stop_at);
    for (int j = 1; j <= FB * N; j++) begin
      step();
      if (pulse_at > 0 && j == pulse_at + 1) bus.tx_valid = 1'b0;
      chk("tx_bit", 32'(tx), 32'(frame_bit(b, (j - 1) / N)));
      chk("busy", 32'(tx_busy), 32'd1);
      chk("ready", 32'(bus.tx_ready), 32'(j == FB * N));
      if (stop_at > 0 && j == stop_at) return;
      if (pulse_at > 0 && j == pulse_at) begin
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
      end
    end
  endtask

  task automatic idle_step();
    step();
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int gap;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    // Reset state
    repeat (3) step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    rst_n = 1'b1;
    repeat (100) step();
    chk("post_rst_tx", 32'(tx), 32'd1);
    chk("post_rst_ready", 32'(bus.tx_ready), 32'd1);
    chk("post_rst_busy", 32'(tx_busy), 32'd0);

    // Single byte
    send_start(8'hA5);
    bus.tx_valid = 1'b0;
    check_frame(8'hA5, 0, 0);
    idle_step();

    // Back-to-back with valid held: one idle cycle between frames
    send_start(8'h00);
    bus.tx_data = 8'hFF;
    check_frame(8'h00, 0, 0);
    idle_step();
    chk("b2b_accept", 32'(bus.tx_ready), 32'd0);
    bus.tx_valid = 1'b0;
    check_frame(8'hFF, 0, 0);
    idle_step();

    // Mid-frame valid pulse is ignored
    b = 8'($urandom);
    send_start(b);
    bus.tx_valid = 1'b0;
    check_frame(b, 5 * N + 3, 0);
    repeat (20) step();
    chk("pulse_no_frame_tx", 32'(tx), 32'd1);
    chk("pulse_no_frame_rdy", 32'(bus.tx_ready), 32'd1);

    // Reset during the 4th data bit (a 0), then 0x81
    b = 8'($urandom) & 8'hF7;
    send_start(b);
    bus.tx_valid = 1'b0;
    check_frame(b, 0, 4 * N + 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_ready", 32'(bus.tx_ready), 32'd1);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    send_start(8'h81);
    bus.tx_valid = 1'b0;
    check_frame(8'h81, 0, 0);
    idle_step();

    // Parity patterns (plain frames in the default build)
    send_start(8'h07);
    bus.tx_valid = 1'b0;
    check_frame(8'h07, 0, 0);
    idle_step();
    send_start(8'h03);
    bus.tx_valid = 1'b0;
    check_frame(8'h03, 0, 0);
    idle_step();

    // Random bytes with random idle gaps
    for (int r = 0; r < 4; r++) begin
      b = 8'($urandom);
      gap = int'($urandom_range(0, 5));
      repeat (gap) step();
      send_start(b);
      bus.tx_valid = 1'b0;
      check_frame(b, 0, 0);
      idle_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit side of the team's UART: accepts one byte per valid/ready handshake and shifts it out on `tx` as a standard 8N1 frame (optionally 8E1), LSB first. It sits opposite the UART receiver path on the same link and uses the same `BAUD_RATE_NUMBER` clock-cycles-per-bit convention. Bit timing comes from an internal restartable baud counter, so frames start immediately on acceptance and are not aligned to a free-running tick.

## Interface
- `BAUD_RATE_NUMBER`, 10416, clock cycles per serial bit (100 MHz / 9600 baud); legal range 2..16384.
- `clk`  input  1  system clock, all logic on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `tx_data`  input  8  byte to send; sampled only on handshake
- `tx_valid`  input  1  producer has a byte
- `tx_ready`  output  1  block can accept a byte (high only in IDLE)
- `tx`  output  1  serial line, idle high
- `tx_busy`  output  1  high from the cycle after acceptance until the frame ends

## Operation
- One clock; reset is asynchronous and active-low.
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, state IDLE, baud counter = `BAUD_RATE_NUMBER`-1, shift register = 0.
- Handshake: the byte is accepted on a rising edge where `tx_valid` && `tx_ready`. `tx_data` is latched into the shift register. `tx_valid` without `tx_ready` is ignored, with no queueing.
- FSM states:
  - IDLE: `tx`=1. On accept, go to START.
  - START: `tx`=0.
  - DATA: bit index 0..7; `tx` = shift register bit 0; shift right at each bit boundary.
  - PARITY: only when the macro is defined.
  - STOP: `tx`=1. Return to IDLE.
- Baud counter: 14-bit down-counter. It is loaded with `BAUD_RATE_NUMBER`-1 on accept and at every bit boundary, and decrements otherwise. A bit boundary occurs when the counter is 0. Each bit therefore lasts exactly `BAUD_RATE_NUMBER` cycles. The counter holds its load value while in IDLE.
- DATA to next state after index 7 completes. The index wraps from 7 back to 0 only on a new frame.
- `tx` is a registered output with no combinational path from inputs.
- Reset mid-frame: `tx` goes high immediately (asynchronous). The in-flight byte is discarded, and the block resumes in IDLE after deassertion.

## Timing
- Accept at edge k: `tx` falls and `tx_busy` rises at edge k+1. `tx_ready` is low from k+1.
- Frame length is 10·N cycles (11·N with parity), where N = `BAUD_RATE_NUMBER`.
- The last STOP cycle is edge k+10N. At edge k+10N+1 the FSM is in IDLE, `tx_ready`=1 and `tx_busy`=0.
- Back-to-back bytes: the earliest next accept is at edge k+10N+1. Minimum idle-high gap between frames is 1 cycle.
- Handshake latency: 1 cycle from accept to first line transition.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds a PARITY state after DATA.
  - Parity bit is even parity, the XOR of the 8 latched data bits.
  - It is computed at accept and held stable for N cycles.
  - The frame becomes 11 bits.
- Undefined: no PARITY state, 10-bit frame, and no parity logic is synthesized.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_BITS`=8.
  - `BAUD_RATE_NUMBER_DEFAULT`=10416.
  - The TX state enum: IDLE, START, DATA, PARITY, STOP.
  - Frame-length constants.
- One sub-module, `uart_tx_baud_counter`:
  - Restartable 14-bit down-counter.
  - Inputs: `clk`, `rst_n`, `restart`.
  - Output: `bit_done`, pulsed when the count is 0.
- The FSM, shift register and handshake live in the top module.

## Test plan
Simulate with N=16.
- Reset check: hold `rst_n`=0 → `tx`=1, `tx_ready`=1, `tx_busy`=0. Release and wait 100 cycles → outputs unchanged.
- Single byte 0xA5 accepted at edge k → `tx` low for 16 cycles from k+1, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16 cycles. `tx_ready` returns at k+161.
- Back-to-back 0x00 then 0xFF with `tx_valid` held high → second start bit at edge k+162, and exactly 1 idle-high cycle between frames.
- `tx_valid` pulsed mid-frame with 0x3C → ignored, and the current frame is unaltered.
- Reset asserted at the 4th data bit → `tx`=1 immediately. After release, a new byte 0x81 transmits correctly.
- With `UART_TX_PARITY_EN`: 0x07 → parity bit 1 after the data bits and an 11-bit frame. 0x03 → parity bit 0.
